// File: rtl/vdic_dut_pkg.sv
// Shared types and constants for the VDIC responder: command codes, FSM states,
// status bit positions and the default packet size.
package vdic_dut_pkg;

    localparam int MAX_DATA_DEFAULT = 8;
    localparam int RES_W            = 16;

    localparam int ERR_DATA_BIT   = 0;
    localparam int ERR_CMD_BIT    = 1;
    localparam int ERR_PARITY_BIT = 2;

    typedef enum logic [7:0] {
        CMD_NOP = 8'h00,
        CMD_AND = 8'h01,
        CMD_OR  = 8'h02,
        CMD_XOR = 8'h03,
        CMD_ADD = 8'h10,
        CMD_SUB = 8'h20
    } command_t;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        EXEC,
        SEND_HI,
        SEND_LO,
        SEND_STAT
    } state_t;

endpackage

// File: rtl/vdic_dut_reducer.sv
// Combinational reduction of the collected byte buffer under the captured command.
// Produces the 16-bit result and flags command codes it does not recognise.
module vdic_dut_reducer
    import vdic_dut_pkg::*;
#(
    parameter int MAX_DATA = MAX_DATA_DEFAULT,
    parameter int DW       = 8,
    parameter int CNT_W    = $clog2(MAX_DATA + 1)
) (
    input  logic [MAX_DATA-1:0][DW-1:0] buffer_i,
    input  logic [CNT_W-1:0]            count_i,
    input  logic [DW-1:0]               cmd_i,
    output logic [RES_W-1:0]            result_o,
    output logic                        errCmd_o
);

    logic [DW-1:0]    accAnd;
    logic [DW-1:0]    accOr;
    logic [DW-1:0]    accXor;
    logic [RES_W-1:0] accAdd;
    logic [RES_W-1:0] accSub;
    logic [RES_W-1:0] byteExt;

    always_comb begin
        accAnd  = '1;
        accOr   = '0;
        accXor  = '0;
        accAdd  = '0;
        accSub  = RES_W'(buffer_i[0]);
        byteExt = '0;
        for (int i = 0; i < MAX_DATA; i++) begin
            byteExt = RES_W'(buffer_i[i]);
            if (CNT_W'(i) < count_i) begin
                accAnd = accAnd & buffer_i[i];
                accOr  = accOr  | buffer_i[i];
                accXor = accXor ^ buffer_i[i];
                accAdd = accAdd + byteExt;
                // byte0 is the minuend; every later byte is subtracted from it
                if (i != 0) begin
                    accSub = accSub - byteExt;
                end
            end
        end

        result_o = '0;
        errCmd_o = 1'b0;
        case (cmd_i)
            CMD_NOP: result_o = '0;
            CMD_AND: result_o = RES_W'(accAnd);
            CMD_OR:  result_o = RES_W'(accOr);
            CMD_XOR: result_o = RES_W'(accXor);
            CMD_ADD: result_o = accAdd;
            CMD_SUB: result_o = accSub;
            default: errCmd_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/vdic_dut_responder.sv
// Responder end of the VDIC packet interface: collects data bytes, executes the
// command byte and streams result/status on a ready/valid channel.
// Define VDIC_DUT_RESPONDER_PARITY_EN to add din_par and the ERR_PARITY check.
module vdic_dut_responder
    import vdic_dut_pkg::*;
#(
    parameter int MAX_DATA = MAX_DATA_DEFAULT,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable_n,
    input  logic [DW-1:0] din,
    input  logic          din_cmd,
`ifdef VDIC_DUT_RESPONDER_PARITY_EN
    input  logic          din_par,
`endif
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy
);

    localparam int CNT_W = $clog2(MAX_DATA + 1);

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [MAX_DATA-1:0][DW-1:0] buffer_q, buffer_d;
    logic [DW-1:0]               cmd_q, cmd_d;
    logic                        errData_q, errData_d;
    logic                        errPar_q, errPar_d;
    logic [RES_W-1:0]            result_q, result_d;
    logic [DW-1:0]               status_q, status_d;
    logic [DW-1:0]               dout_q, dout_d;
    logic                        doutValid_q, doutValid_d;
    logic                        busy_q, busy_d;

    logic                        byteFire;
    logic                        parErr;
    logic [RES_W-1:0]            redResult;
    logic                        redErrCmd;

`ifdef VDIC_DUT_RESPONDER_PARITY_EN
    assign parErr = ~(^{din, din_cmd, din_par});
`else
    assign parErr = 1'b0;
`endif

    assign byteFire   = !enable_n && !busy_q;
    assign dout       = dout_q;
    assign dout_valid = doutValid_q;
    assign busy       = busy_q;

    vdic_dut_reducer #(
        .MAX_DATA (MAX_DATA),
        .DW       (DW),
        .CNT_W    (CNT_W)
    ) u_reducer (
        .buffer_i (buffer_q),
        .count_i  (count_q),
        .cmd_i    (cmd_q),
        .result_o (redResult),
        .errCmd_o (redErrCmd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            buffer_q    <= '0;
            cmd_q       <= '0;
            errData_q   <= 1'b0;
            errPar_q    <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
            dout_q      <= '0;
            doutValid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            buffer_q    <= buffer_d;
            cmd_q       <= cmd_d;
            errData_q   <= errData_d;
            errPar_q    <= errPar_d;
            result_q    <= result_d;
            status_q    <= status_d;
            dout_q      <= dout_d;
            doutValid_q <= doutValid_d;
            busy_q      <= busy_d;
        end
    end

    // Each SEND state first loads its byte (valid rises), then on acceptance
    // loads the next state's byte directly so accepted bytes flow back-to-back.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        buffer_d    = buffer_q;
        cmd_d       = cmd_q;
        errData_d   = errData_q;
        errPar_d    = errPar_q;
        result_d    = result_q;
        status_d    = status_q;
        dout_d      = dout_q;
        doutValid_d = doutValid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (byteFire) begin
                    errPar_d = errPar_q | parErr;
                    if (din_cmd) begin
                        cmd_d     = din;
                        count_d   = '0;
                        errData_d = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = EXEC;
                    end else begin
                        buffer_d[0] = din;
                        count_d     = CNT_W'(1);
                        state_d     = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (byteFire) begin
                    errPar_d = errPar_q | parErr;
                    if (din_cmd) begin
                        cmd_d   = din;
                        busy_d  = 1'b1;
                        state_d = EXEC;
                    end else if (count_q == CNT_W'(MAX_DATA)) begin
                        errData_d = 1'b1;
                    end else begin
                        for (int i = 0; i < MAX_DATA; i++) begin
                            if (CNT_W'(i) == count_q) begin
                                buffer_d[i] = din;
                            end
                        end
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            EXEC: begin
                result_d                 = redResult;
                status_d                 = '0;
                status_d[ERR_DATA_BIT]   = errData_q;
                status_d[ERR_CMD_BIT]    = redErrCmd;
                status_d[ERR_PARITY_BIT] = errPar_q;
                if ((status_d != '0) || (cmd_q == CMD_NOP)) begin
                    state_d = SEND_STAT;
                end else begin
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                if (!doutValid_q) begin
                    dout_d      = result_q[15:8];
                    doutValid_d = 1'b1;
                end else if (dout_ready) begin
                    dout_d  = result_q[7:0];
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                if (!doutValid_q) begin
                    dout_d      = result_q[7:0];
                    doutValid_d = 1'b1;
                end else if (dout_ready) begin
                    dout_d  = status_q;
                    state_d = SEND_STAT;
                end
            end
            SEND_STAT: begin
                if (!doutValid_q) begin
                    dout_d      = status_q;
                    doutValid_d = 1'b1;
                end else if (dout_ready) begin
                    dout_d      = '0;
                    doutValid_d = 1'b0;
                    busy_d      = 1'b0;
                    count_d     = '0;
                    buffer_d    = '0;
                    cmd_d       = '0;
                    errData_d   = 1'b0;
                    errPar_d    = 1'b0;
                    status_d    = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vdic_dut_responder.sv
// Scoreboard testbench for vdic_dut_responder: directed packets push expected
// response bytes, a negedge monitor pops and compares every accepted byte.
module tb_vdic_dut_responder;

   logic       clk;
   logic       rst_n;
   logic       enable_n;
   logic [7:0] din;
   logic       din_cmd;
`ifdef VDIC_DUT_RESPONDER_PARITY_EN
   logic       din_par;
`endif
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       busy;

   int         total = 0;
   int         bad = 0;
   int         popIdx = 0;
   logic [7:0] expQ[$];
   logic [7:0] dataQ[$];
   logic [7:0] expByte;

   vdic_dut_responder #(
      .MAX_DATA (8),
      .DW       (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable_n   (enable_n),
      .din        (din),
      .din_cmd    (din_cmd),
`ifdef VDIC_DUT_RESPONDER_PARITY_EN
      .din_par    (din_par),
`endif
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, actual, expected);
      end
   endtask

   // Drives one byte for exactly one clock; starts and ends just after a rising edge.
   task automatic applyStimulus(input logic [7:0] b, input logic isCmd);
      enable_n = 1'b0;
      din      = b;
      din_cmd  = isCmd;
`ifdef VDIC_DUT_RESPONDER_PARITY_EN
      din_par  = ~(^{b, isCmd});
`endif
      @(posedge clk);
      #1;
      enable_n = 1'b1;
      din_cmd  = 1'b0;
      din      = 8'h00;
   endtask

   task automatic waitValid(input string name);
      int cyc = 0;
      while (!dout_valid && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checkOutput({name, "_valid"}, 8'(dout_valid), 8'h01);
   endtask

   task automatic waitDrain(input string name);
      int cyc = 0;
      while (expQ.size() != 0 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checkOutput({name, "_drain"}, 8'(expQ.size()), 8'h00);
      expQ.delete();
      checkOutput({name, "_busy"}, 8'(busy), 8'h00);
      checkOutput({name, "_vldlow"}, 8'(dout_valid), 8'h00);
   endtask

   // Sends dataQ then the command byte; expected bytes must already be in expQ.
   task automatic runPacket(input string name, input logic [7:0] cmd);
      foreach (dataQ[i]) applyStimulus(dataQ[i], 1'b0);
      applyStimulus(cmd, 1'b1);
      waitDrain(name);
   endtask

   // Monitor: every byte the consumer accepts is compared with the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && dout_valid && dout_ready) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL extra_byte: got 0x%02h expected none", dout);
            end else begin
               expByte = expQ.pop_front();
               checkOutput($sformatf("dout#%0d", popIdx), dout, expByte);
            end
            popIdx++;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      enable_n   = 1'b1;
      din        = 8'h00;
      din_cmd    = 1'b0;
`ifdef VDIC_DUT_RESPONDER_PARITY_EN
      din_par    = 1'b1;
`endif
      dout_ready = 1'b1;
      #12;
      checkOutput("rst_dout", dout, 8'h00);
      checkOutput("rst_valid", 8'(dout_valid), 8'h00);
      checkOutput("rst_busy", 8'(busy), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] ADD 05+03 with latency checks");
      expQ = '{8'h00, 8'h08, 8'h00};
      applyStimulus(8'h05, 1'b0);
      applyStimulus(8'h03, 1'b0);
      applyStimulus(8'h10, 1'b1);
      checkOutput("lat_busy_n", 8'(busy), 8'h01);
      checkOutput("lat_valid_n", 8'(dout_valid), 8'h00);
      @(posedge clk);
      #1;
      checkOutput("lat_valid_n1", 8'(dout_valid), 8'h00);
      @(posedge clk);
      #1;
      checkOutput("lat_valid_n2", 8'(dout_valid), 8'h01);
      waitDrain("add1");

      $display("[TB] SUB 01-02");
      dataQ = '{8'h01, 8'h02};
      expQ  = '{8'hFF, 8'hFF, 8'h00};
      runPacket("sub", 8'h20);

      $display("[TB] 8x FF ADD and AND");
      dataQ.delete();
      for (int i = 0; i < 8; i++) dataQ.push_back(8'hFF);
      expQ = '{8'h07, 8'hF8, 8'h00};
      runPacket("add8", 8'h10);
      expQ = '{8'h00, 8'hFF, 8'h00};
      runPacket("and8", 8'h01);

      $display("[TB] XOR 0F^3C^55");
      dataQ = '{8'h0F, 8'h3C, 8'h55};
      expQ  = '{8'h00, 8'h66, 8'h00};
      runPacket("xor", 8'h03);

      $display("[TB] error and NOP packets");
      dataQ.delete();
      for (int i = 0; i < 9; i++) dataQ.push_back(8'h01);
      expQ = '{8'h01};
      runPacket("over", 8'h10);
      dataQ.delete();
      expQ = '{8'h01};
      runPacket("nodata", 8'h10);
      dataQ = '{8'h11};
      expQ  = '{8'h02};
      runPacket("badcmd", 8'h7E);
      expQ  = '{8'h00};
      runPacket("nop", 8'h00);

      $display("[TB] backpressure and dropped bytes while busy");
      dout_ready = 1'b0;
      expQ = '{8'h00, 8'h50, 8'h00};
      applyStimulus(8'h20, 1'b0);
      applyStimulus(8'h30, 1'b0);
      applyStimulus(8'h10, 1'b1);
      waitValid("bp");
      for (int k = 0; k < 3; k++) begin
         applyStimulus(8'hAA, (k == 2));
         checkOutput($sformatf("bp_hold_valid%0d", k), 8'(dout_valid), 8'h01);
         checkOutput($sformatf("bp_hold_dout%0d", k), dout, 8'h00);
      end
      dout_ready = 1'b1;
      waitDrain("bp");
      dataQ = '{8'h0F, 8'h01};
      expQ  = '{8'h00, 8'h0E, 8'h00};
      runPacket("after_bp", 8'h20);

      $display("[TB] reset during SEND_LO");
      dout_ready = 1'b0;
      expQ = '{8'h00, 8'h08, 8'h00};
      applyStimulus(8'h05, 1'b0);
      applyStimulus(8'h03, 1'b0);
      applyStimulus(8'h10, 1'b1);
      waitValid("rstlo");
      dout_ready = 1'b1;
      @(posedge clk);
      #1;
      dout_ready = 1'b0;
      checkOutput("rstlo_dout", dout, 8'h08);
      checkOutput("rstlo_valid", 8'(dout_valid), 8'h01);
      expQ.delete();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rstlo_async_valid", 8'(dout_valid), 8'h00);
      checkOutput("rstlo_async_busy", 8'(busy), 8'h00);
      @(negedge clk);
      rst_n      = 1'b1;
      dout_ready = 1'b1;
      @(posedge clk);
      #1;
      dataQ = '{8'h0A};
      expQ  = '{8'h00, 8'h0A, 8'h00};
      runPacket("or_after_rst", 8'h02);

      repeat (4) @(posedge clk);
      #1;
      checkOutput("final_queue", 8'(expQ.size()), 8'h00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
